// File: rtl/gen_sequencer_if.sv
// Handshake bundle between the generation sequencer and its environment
// (renderer, double buffer, life-logic engines).
interface gen_sequencer_if #(
    parameter int NUM_ENGINES = 4,
    parameter int SPEED_W     = 4,
    parameter int GEN_W       = 16
);
    logic                   run_in;
    logic                   step_in;
    logic [SPEED_W-1:0]     speed_in;
    logic [NUM_ENGINES-1:0] engine_done_in;
    logic                   render_done_in;
    logic                   buf_ready_in;
    logic                   engine_start_out;
    logic                   buf_swap_out;
    logic                   busy_out;
    logic [GEN_W-1:0]       gen_count_out;
    logic                   timeout_out;

    // Environment side: drives control, done and frame signals.
    modport master (
        output run_in, step_in, speed_in, engine_done_in, render_done_in, buf_ready_in,
        input  engine_start_out, buf_swap_out, busy_out, gen_count_out, timeout_out
    );

    // Sequencer side.
    modport slave (
        input  run_in, step_in, speed_in, engine_done_in, render_done_in, buf_ready_in,
        output engine_start_out, buf_swap_out, busy_out, gen_count_out, timeout_out
    );
endinterface

// File: rtl/gen_sequencer.sv
// Generation sequencer: starts all engines, collects their done pulses, swaps
// the double buffer on a frame boundary, with run/pause/step, speed and watchdog.
module gen_sequencer #(
    parameter int NUM_ENGINES = 4,
    parameter int SPEED_W     = 4,
    parameter int GEN_W       = 16,
    parameter int TIMEOUT_W   = 20
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    gen_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAMES,
        START,
        COMPUTE,
        WAIT_SWAP
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = '1;

    state_t                 state_q;
    logic [SPEED_W-1:0]     frame_cnt_q;
    logic [NUM_ENGINES-1:0] done_mask_q;
    logic [NUM_ENGINES-1:0] done_mask_d;
    logic [TIMEOUT_W-1:0]   wd_q;
    logic [TIMEOUT_W-1:0]   wd_d;
    logic [GEN_W-1:0]       gen_q;
    logic                   start_q;
    logic                   swap_q;
    logic                   busy_q;
    logic                   timeout_q;

    // Done pulses arriving this cycle count toward completion immediately.
    assign done_mask_d = done_mask_q | bus.engine_done_in;
    assign wd_d        = wd_q + TIMEOUT_W'(1);

    // NOTE: every register here is written with <= so all state updates see
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: the asynchronous reset clears every register, so a
            // generation in flight is abandoned without a swap.
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            done_mask_q <= '0;
            wd_q        <= '0;
            gen_q       <= '0;
            start_q     <= 1'b0;
            swap_q      <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            swap_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.step_in) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.run_in) begin
                        state_q     <= WAIT_FRAMES;
                        frame_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT_FRAMES: begin
                    if (!bus.run_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_cnt_q == bus.speed_in) begin
                        state_q <= START;
                        start_q <= 1'b1;
                    end else if (bus.render_done_in) begin
                        frame_cnt_q <= frame_cnt_q + SPEED_W'(1);
                    end
                end
                START: begin
                    done_mask_q <= '0;
                    wd_q        <= '0;
                    timeout_q   <= 1'b0;
                    state_q     <= COMPUTE;
                end
                COMPUTE: begin
                    done_mask_q <= done_mask_d;
                    wd_q        <= wd_d;
                    if (&done_mask_d) begin
                        state_q <= WAIT_SWAP;
                    end else if (wd_d == WD_LIMIT) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    // Only a frame boundary with a ready buffer commits the generation.
                    if (bus.render_done_in && bus.buf_ready_in) begin
                        swap_q <= 1'b1;
                        gen_q  <= gen_q + GEN_W'(1);
                        if (bus.run_in) begin
                            state_q     <= WAIT_FRAMES;
                            frame_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.engine_start_out = start_q;
    assign bus.buf_swap_out     = swap_q;
    assign bus.busy_out         = busy_q;
    assign bus.gen_count_out    = gen_q;
    assign bus.timeout_out      = timeout_q;
endmodule

// File: tb/tb_gen_sequencer.sv
// Directed bench for gen_sequencer: step, free run, delayed swap, watchdog,
// run drop, async reset and generation-counter wrap.
module tb_gen_sequencer;
    logic clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_gen;
    logic       rd;
    int         rd_since;
    int         gens;
    int         sw;
    logic       phase_wait;
    logic       sp1;
    logic       sp2;

    gen_sequencer_if #(.NUM_ENGINES(4), .SPEED_W(4), .GEN_W(4)) sif ();

    gen_sequencer #(
        .NUM_ENGINES(4),
        .SPEED_W    (4),
        .GEN_W      (4),
        .TIMEOUT_W  (6)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One paused generation: step, all engines done at once, immediate swap.
    task automatic do_step();
        sif.step_in = 1'b1;
        tick();
        sif.step_in = 1'b0;
        check("step_start", sif.engine_start_out, 1);
        tick();
        check("step_timeout_clr", sif.timeout_out, 0);
        sif.engine_done_in = 4'hF;
        tick();
        sif.engine_done_in = 4'h0;
        sif.render_done_in = 1'b1;
        sif.buf_ready_in   = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        exp_gen = exp_gen + 4'd1;
        check("step_swap", sif.buf_swap_out, 1);
        check("step_gen", sif.gen_count_out, exp_gen);
    endtask

    initial begin
        rst_n              = 1'b0;
        sif.run_in         = 1'b0;
        sif.step_in        = 1'b0;
        sif.speed_in       = 4'd0;
        sif.engine_done_in = 4'h0;
        sif.render_done_in = 1'b0;
        sif.buf_ready_in   = 1'b0;
        exp_gen            = 4'd0;
        tick();
        tick();
        check("rst_start", sif.engine_start_out, 0);
        check("rst_swap", sif.buf_swap_out, 0);
        check("rst_busy", sif.busy_out, 0);
        check("rst_gen", sif.gen_count_out, 0);
        check("rst_timeout", sif.timeout_out, 0);
        rst_n = 1'b1;
        tick();

        // Single step with staggered engine completion and a late frame boundary.
        sif.step_in = 1'b1;
        tick();
        sif.step_in = 1'b0;
        check("t1_start_hi", sif.engine_start_out, 1);
        check("t1_busy_hi", sif.busy_out, 1);
        tick();
        check("t1_start_lo", sif.engine_start_out, 0);
        for (int c = 1; c <= 20; c++) begin
            sif.engine_done_in = {c == 20, c == 15, c == 12, c == 10};
            tick();
        end
        sif.engine_done_in = 4'h0;
        sw = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            sw += int'(sif.buf_swap_out);
        end
        check("t1_no_early_swap", sw, 0);
        check("t1_busy_wait", sif.busy_out, 1);
        sif.render_done_in = 1'b1;
        sif.buf_ready_in   = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        exp_gen = exp_gen + 4'd1;
        check("t1_swap", sif.buf_swap_out, 1);
        check("t1_gen", sif.gen_count_out, exp_gen);
        check("t1_busy_lo", sif.busy_out, 0);
        tick();
        check("t1_swap_once", sif.buf_swap_out, 0);

        // Free run at speed 2 for 10 generations.
        sif.speed_in = 4'd2;
        rd_since     = 0;
        phase_wait   = 1'b1;
        gens         = 0;
        sp1          = 1'b0;
        sp2          = 1'b0;
        for (int cyc = 0; cyc < 2000 && gens < 10; cyc++) begin
            rd                 = (cyc % 7 == 6);
            sif.run_in         = 1'b1;
            sif.render_done_in = rd;
            sif.buf_ready_in   = 1'b1;
            sif.engine_done_in = sp2 ? 4'hF : 4'h0;
            tick();
            if (sif.engine_start_out) begin
                check("t2_frames_before_start", rd_since, 2);
                rd_since   = 0;
                phase_wait = 1'b0;
            end else if (phase_wait && rd) begin
                rd_since++;
            end
            if (sif.buf_swap_out) begin
                check("t2_swap_after_rd", rd, 1);
                gens++;
                exp_gen    = exp_gen + 4'd1;
                phase_wait = 1'b1;
                rd_since   = 0;
            end
            sp2 = sp1;
            sp1 = sif.engine_start_out;
        end
        sif.render_done_in = 1'b0;
        sif.engine_done_in = 4'h0;
        check("t2_gens", gens, 10);
        check("t2_gen", sif.gen_count_out, exp_gen);
        sif.run_in = 1'b0;
        tick();
        tick();
        check("t2_busy_lo", sif.busy_out, 0);

        // Buffer not ready on the first frame boundary after compute.
        sif.speed_in = 4'd0;
        sif.step_in  = 1'b1;
        tick();
        sif.step_in = 1'b0;
        tick();
        sif.engine_done_in = 4'hF;
        tick();
        sif.engine_done_in = 4'h0;
        sif.render_done_in = 1'b1;
        sif.buf_ready_in   = 1'b0;
        tick();
        sif.render_done_in = 1'b0;
        sif.buf_ready_in   = 1'b1;
        check("t3_no_swap", sif.buf_swap_out, 0);
        tick();
        tick();
        check("t3_no_swap_later", sif.buf_swap_out, 0);
        check("t3_gen_hold", sif.gen_count_out, exp_gen);
        sif.render_done_in = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        exp_gen = exp_gen + 4'd1;
        check("t3_swap", sif.buf_swap_out, 1);
        check("t3_gen", sif.gen_count_out, exp_gen);

        // Watchdog: engine 3 never completes, limit 63 compute cycles.
        sif.step_in = 1'b1;
        tick();
        sif.step_in = 1'b0;
        tick();
        sif.engine_done_in = 4'b0111;
        tick();
        sif.engine_done_in = 4'h0;
        repeat (61) tick();
        check("t4_timeout_pre", sif.timeout_out, 0);
        check("t4_busy_pre", sif.busy_out, 1);
        tick();
        check("t4_timeout", sif.timeout_out, 1);
        check("t4_busy_lo", sif.busy_out, 0);
        check("t4_gen_hold", sif.gen_count_out, exp_gen);
        sif.render_done_in = 1'b1;
        sif.buf_ready_in   = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        check("t4_no_swap", sif.buf_swap_out, 0);
        check("t4_sticky", sif.timeout_out, 1);
        do_step();

        // run_in dropped during COMPUTE: the generation still completes.
        sif.speed_in = 4'd0;
        sif.run_in   = 1'b1;
        tick();
        tick();
        check("t5_start", sif.engine_start_out, 1);
        sif.run_in = 1'b0;
        tick();
        tick();
        sif.engine_done_in = 4'hF;
        tick();
        sif.engine_done_in = 4'h0;
        check("t5_busy_hi", sif.busy_out, 1);
        sif.render_done_in = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        exp_gen = exp_gen + 4'd1;
        check("t5_swap", sif.buf_swap_out, 1);
        check("t5_gen", sif.gen_count_out, exp_gen);
        check("t5_busy_lo", sif.busy_out, 0);

        // Async reset in the middle of COMPUTE.
        sif.step_in = 1'b1;
        tick();
        sif.step_in = 1'b0;
        tick();
        sif.engine_done_in = 4'b0011;
        tick();
        sif.engine_done_in = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        exp_gen = 4'd0;
        check("t5r_busy", sif.busy_out, 0);
        check("t5r_gen", sif.gen_count_out, exp_gen);
        check("t5r_start", sif.engine_start_out, 0);
        check("t5r_swap", sif.buf_swap_out, 0);
        check("t5r_timeout", sif.timeout_out, 0);
        tick();
        rst_n = 1'b1;
        sif.engine_done_in = 4'hF;
        sif.render_done_in = 1'b1;
        tick();
        sif.engine_done_in = 4'h0;
        sif.render_done_in = 1'b0;
        tick();
        check("t5r_no_swap", sif.buf_swap_out, 0);
        check("t5r_idle", sif.busy_out, 0);

        // 17 steps on a 4-bit counter wrap it to 1.
        repeat (17) do_step();
        check("t6_wrap", sif.gen_count_out, 1);

        // Simultaneous step and run go straight to START.
        sif.step_in = 1'b1;
        sif.run_in  = 1'b1;
        tick();
        sif.step_in = 1'b0;
        sif.run_in  = 1'b0;
        check("t6_direct_start", sif.engine_start_out, 1);
        check("t6_busy", sif.busy_out, 1);
        tick();
        sif.engine_done_in = 4'hF;
        tick();
        sif.engine_done_in = 4'h0;
        sif.render_done_in = 1'b1;
        tick();
        sif.render_done_in = 1'b0;
        exp_gen = exp_gen + 4'd1;
        check("t6_swap", sif.buf_swap_out, 1);
        check("t6_gen", sif.gen_count_out, exp_gen);
        tick();
        check("t6_idle", sif.busy_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gen_sequencer.md
# gen_sequencer

Parametrised generation sequencer for the Game of Life datapath, replacing the fixed two-signal synchronizer. It sits between the renderer, the double buffer and N parallel life-logic engines. It issues one start pulse per generation to all engines and waits for every engine to finish. It then swaps the buffers only on a frame boundary. It adds run/pause/single-step modes, frame-based speed control, a generation counter and a compute watchdog.

## Interface
- NUM_ENGINES, 4: number of life-logic engines; one done bit per engine.
- SPEED_W, 4: width of speed_in (frames to wait between generations).
- GEN_W, 16: width of the generation counter.
- TIMEOUT_W, 20: watchdog width; compute limit is 2^TIMEOUT_W-1 cycles.

- clk_in  in  1  system clock; the only clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- run_in  in  1  level; 1 = free-run generations, 0 = pause.
- step_in  in  1  single-cycle pulse; requests one generation while paused.
- speed_in  in  SPEED_W  frames to wait before each generation (0 = none).
- engine_done_in  in  NUM_ENGINES  per-engine single-cycle done pulses.
- render_done_in  in  1  single-cycle end-of-frame pulse from the renderer.
- buf_ready_in  in  1  double buffer can accept a swap.
- engine_start_out  out  1  single-cycle start pulse to all engines.
- buf_swap_out  out  1  single-cycle buffer swap pulse.
- busy_out  out  1  high whenever the state is not IDLE.
- gen_count_out  out  GEN_W  completed generations; wraps modulo 2^GEN_W.
- timeout_out  out  1  sticky flag for a watchdog abort.

## Operation
- States: IDLE, WAIT_FRAMES, START, COMPUTE, WAIT_SWAP.
- IDLE
  - step_in=1 -> START. step has priority over run_in in the same cycle.
  - Otherwise run_in=1 -> WAIT_FRAMES with frame_cnt=0.
- WAIT_FRAMES
  - Each render_done_in pulse increments frame_cnt (SPEED_W bits).
  - When frame_cnt==speed_in (checked every cycle, so speed_in=0 exits on the first cycle) -> START.
  - run_in=0 -> IDLE. This takes priority over the exit to START.
  - step_in is ignored in this state.
- START
  - Register engine_start_out=1 for one cycle, clear done_mask, clear timeout_out, clear the watchdog counter, then -> COMPUTE.
  - engine_done_in pulses in this cycle are ignored.
- COMPUTE
  - done_mask |= engine_done_in each cycle.
  - When (done_mask | engine_done_in) is all ones -> WAIT_SWAP.
  - The watchdog increments each cycle. On reaching 2^TIMEOUT_W-1 without completion: set timeout_out, go to IDLE, no swap, gen_count unchanged.
  - render_done_in and step_in are ignored in this state.
  - run_in going low does not abort; the generation completes.
- WAIT_SWAP
  - On a cycle with render_done_in=1 and buf_ready_in=1: buf_swap_out=1 next cycle and gen_count_out+=1 (wrap). Then -> WAIT_FRAMES with frame_cnt=0 if run_in=1, else -> IDLE.
  - render_done_in with buf_ready_in=0 is not latched; wait for a later frame boundary.
  - The render_done pulse consumed by the swap does not count toward frame_cnt.
- Repeated done pulses from the same engine are harmless because the mask is OR-based.

## Timing
- Reset (asynchronous, any state)
  - State IDLE.
  - engine_start_out=0, buf_swap_out=0, busy_out=0, gen_count_out=0, timeout_out=0.
  - frame_cnt=0, done_mask=0, watchdog=0.
  - Reset in mid-generation abandons it; no swap is issued.
- All outputs are registered.
- step_in sampled in IDLE at edge t:
  - engine_start_out is high during cycle t+1 only.
  - busy_out rises at t+1.
- Last engine done sampled at edge t -> state WAIT_SWAP at t+1.
- Swap condition sampled at edge t:
  - buf_swap_out is high for cycle t+1 only.
  - gen_count_out updates at the same edge.
  - busy_out falls at t+1 if returning to IDLE.
- Free-run period: at least speed_in frames plus compute time plus the wait to the next frame boundary. At most one swap per frame.
- Watchdog abort sampled at edge t: timeout_out and IDLE from t+1. timeout_out stays high until the next START or reset.

## Test plan
- Single step, NUM_ENGINES=4, engines finish at +10/+12/+15/+20 cycles, render_done 50 cycles later with buf_ready=1 -> one start pulse, one swap pulse exactly one cycle after render_done, gen_count 0->1, busy_out low afterwards.
- Free run, speed_in=2, 10 generations -> exactly 2 render_done pulses between each swap and the next start. gen_count=10. No swap ever outside a render_done+1 cycle.
- buf_ready_in=0 on the first frame boundary after compute, 1 on the second -> swap only after the second render_done; gen_count increments once.
- Engine 3 never asserts done, TIMEOUT_W=6 -> timeout_out high after 63 compute cycles, no swap, IDLE. A following step_in clears timeout_out and runs normally.
- run_in dropped during COMPUTE -> generation completes, one swap, then IDLE. Async reset asserted mid-COMPUTE -> all outputs 0 immediately, no swap.
- GEN_W=4, 17 steps -> gen_count_out wraps to 1. Simultaneous step_in and run_in in IDLE -> START directly with no frame wait.
